// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave register interface:
// FSM state encoding, command-width and R/W bit position helpers.
`timescale 1ns/1ps
package spi_slave_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

    localparam int DEFAULT_ADDR_W = 7;

    // Command = R/W bit followed by the address
    function automatic int cmd_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // R/W flag is the MSB of the command word
    function automatic int rw_bit_pos(input int addr_w);
        return addr_w;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Input synchronizers for SCLK, CS and MOSI plus SCLK edge detection.
// sync_ok rises once the chains hold real pad samples after reset, so
// the reset levels (CS high, SCLK low) are never mistaken for pad activity.
`timescale 1ns/1ps
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic spi_sclk,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_s,
    output logic mosi_s,
    output logic sync_ok
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] ok_q;

    // Shift each pad input through its synchronizer chain; reset to idle levels
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            ok_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            ok_q   <= {ok_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edges come from the last two stages: newer vs older sample
    assign sclk_rise = sclk_q[SYNC_STAGES-2] & ~sclk_q[SYNC_STAGES-1];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-2] & sclk_q[SYNC_STAGES-1];
    assign cs_s      = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sync_ok   = ok_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave that turns frames of  R/W | address | data  into
// single-cycle register write strobes or read requests.
// Optional feature: define SPI_SLAVE_ERR_CNT_EN to build the saturating
// aborted-frame counter; otherwise frame_err_cnt is tied to zero.
`timescale 1ns/1ps
module spi_slave_regif
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [15:0]       frame_err_cnt
);

    localparam int CMD_W  = cmd_width(ADDR_W);
    localparam int RW_POS = rw_bit_pos(ADDR_W);
    localparam int MAX_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W  = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, cs_s, mosi_s, sync_ok;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_s      (cs_s),
        .mosi_s    (mosi_s),
        .sync_ok   (sync_ok)
    );

    spi_state_t          state_q, state_d;
    logic                cs_prev_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CMD_W-1:0]    cmd_sr_q;
    logic [DATA_W-2:0]   data_sr_q;
    logic [DATA_W-1:0]   tx_sr_q;
    logic                load_q;
    logic                miso_q;
    logic                rd_en_q, wr_en_q;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                cmd_last, data_last;
    logic [CMD_W-1:0]    cmd_next;
    logic [DATA_W-1:0]   data_next;

    assign cmd_next  = {cmd_sr_q[CMD_W-2:0], mosi_s};
    assign data_next = {data_sr_q, mosi_s};

    // State register; cs_prev_q only counts once the synchronizers carry pad data
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_prev_q <= sync_ok & cs_s;
        end
    end

    // Next-state decode; a last data edge wins over a simultaneous CS release
    always_comb begin
        state_d   = state_q;
        cmd_last  = 1'b0;
        data_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_prev_q && !cs_s) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise && bit_cnt_q == CMD_LAST) begin
                    state_d  = ST_DATA;
                    cmd_last = 1'b1;
                end
            end
            ST_DATA: begin
                if (sclk_rise && bit_cnt_q == DATA_LAST) begin
                    data_last = 1'b1;
                    state_d   = cs_s ? ST_IDLE : ST_DONE;
                end else if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (cs_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift registers, bit counter, register strobes and MISO drive
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            cmd_sr_q  <= '0;
            data_sr_q <= '0;
            tx_sr_q   <= '0;
            load_q    <= 1'b0;
            miso_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            load_q  <= rd_en_q;

            if (state_q == ST_IDLE) begin
                bit_cnt_q <= '0;
            end else if (state_q == ST_CMD && sclk_rise) begin
                cmd_sr_q  <= cmd_next;
                bit_cnt_q <= cmd_last ? '0 : bit_cnt_q + CNT_W'(1);
            end else if (state_q == ST_DATA && sclk_rise) begin
                data_sr_q <= data_next[DATA_W-2:0];
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (cmd_last && !cmd_next[RW_POS]) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= cmd_next[ADDR_W-1:0];
            end

            if (data_last && cmd_sr_q[RW_POS]) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= cmd_sr_q[ADDR_W-1:0];
                wr_data_q <= data_next;
            end

            // Read data lands one cycle after rd_en; falling edges then shift it out
            if (load_q) begin
                tx_sr_q <= rd_data;
            end else if (state_q == ST_DATA && sclk_fall && !cmd_sr_q[RW_POS]) begin
                miso_q  <= tx_sr_q[DATA_W-1];
                tx_sr_q <= tx_sr_q << 1;
            end

            if (state_d != ST_DATA) miso_q <= 1'b0;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~cs_s;
    assign busy        = (state_q != ST_IDLE);
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

`ifdef SPI_SLAVE_ERR_CNT_EN
    logic        abort;
    logic [15:0] err_cnt_q;

    assign abort = cs_s && ((state_q == ST_CMD) || (state_q == ST_DATA && !data_last));

    // Count frames released before completion, saturating at all-ones
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (abort && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign frame_err_cnt = err_cnt_q;
`else
    assign frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_slave_regif.sv
// Self-checking bench for spi_slave_regif: an SPI master drives frames,
// a register-file model answers reads, and an array of expected register
// contents predicts every write and every read-back word.
`timescale 1ns/1ps
module tb_spi_slave_regif;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int HALF   = 50;   // 10 MHz SCLK

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              spi_sclk, spi_cs, spi_mosi;
    logic              spi_miso, spi_miso_oe;
    logic              wr_en, rd_en, busy;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [15:0]       frame_err_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_err  = 0;
    int miso_high;

    logic [DATA_W-1:0]        reg_file [128];
    logic [DATA_W-1:0]        ref_mem  [128];
    logic [ADDR_W+DATA_W-1:0] wr_log [$];
    logic [ADDR_W-1:0]        rd_log [$];

    spi_slave_regif #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .spi_sclk      (spi_sclk),
        .spi_cs        (spi_cs),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Register file: writes on wr_en, read data one cycle after rd_en
    always @(posedge sys_clk) begin
        if (rst) rd_data <= '0;
        else if (rd_en) rd_data <= reg_file[rd_addr];
        if (wr_en) reg_file[wr_addr] = wr_data;
    end

    // Record strobes and any MISO activity away from the active edge
    always @(negedge sys_clk) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
        if (rd_en) rd_log.push_back(rd_addr);
        if (spi_miso === 1'b1) miso_high++;
    end

    // Put the master two ns after a sys_clk rising edge
    task automatic align();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic send_bit(input logic b, output logic m);
        spi_mosi = b;
        #(HALF);
        spi_sclk = 1'b1;
        m = spi_miso;
        #(HALF);
        spi_sclk = 1'b0;
    endtask

    // One master frame; bits past 40 are random filler; optional CS release on the last edge
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] wdata, input int nbits,
                             input bit cs_on_last, input int gap_ns, output logic [31:0] rdata);
        logic b;
        rdata = '0;
        wr_log.delete();
        rd_log.delete();
        miso_high = 0;
        spi_cs = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) b = cmd[7-i];
            else if (i < 40) b = wdata[39-i];
            else b = 1'($urandom);
            spi_mosi = b;
            #(HALF);
            spi_sclk = 1'b1;
            if (cs_on_last && i == nbits - 1) spi_cs = 1'b1;
            if (i >= 8 && i < 40) rdata[39-i] = spi_miso;
            #(HALF);
            spi_sclk = 1'b0;
        end
        #(HALF);
        spi_cs = 1'b1;
        #(gap_ns);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi_sclk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL reset_strobes wr=%b rd=%b exp=0", wr_en, rd_en); end
        checks++; if (wr_addr !== '0 || wr_data !== '0 || rd_addr !== '0) begin failures++; $display("FAIL reset_addr wa=%h wd=%h ra=%h exp=0", wr_addr, wr_data, rd_addr); end
        checks++; if (frame_err_cnt !== 16'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", frame_err_cnt); end
        $display("reset: outputs checked");
        @(posedge sys_clk);
        rst = 1'b0;
        repeat (5) @(posedge sys_clk);
    endtask

    task automatic test_write();
        logic [31:0] cap, d;
        logic [6:0]  a;
        align();
        for (int n = 0; n < 5; n++) begin
            if (n == 0) begin a = 7'h05; d = 32'hDEADBEEF; end
            else begin a = 7'($urandom); d = $urandom; end
            run_frame({1'b1, a}, d, 40, 1'b0, 200, cap);
            ref_mem[a] = d;
            checks++;
            if (wr_log.size() != 1) begin failures++; $display("FAIL write_count got=%0d exp=1", wr_log.size()); end
            else begin
                checks++;
                if (wr_log[0] !== {a, d}) begin failures++; $display("FAIL write_addr_data got=%h exp=%h", wr_log[0], {a, d}); end
            end
            checks++; if (rd_log.size() != 0) begin failures++; $display("FAIL write_rd_en got=%0d exp=0", rd_log.size()); end
            checks++; if (miso_high != 0) begin failures++; $display("FAIL write_miso_active got=%0d exp=0", miso_high); end
            $display("write addr=%h data=%h", a, d);
        end
    endtask

    task automatic test_read();
        logic [31:0] cap;
        logic [6:0]  a;
        align();
        for (int n = 0; n < 5; n++) begin
            a = (n == 0) ? 7'h12 : 7'($urandom);
            run_frame({1'b0, a}, 32'h0, 40, 1'b0, 200, cap);
            checks++;
            if (rd_log.size() != 1) begin failures++; $display("FAIL read_count got=%0d exp=1", rd_log.size()); end
            else begin
                checks++;
                if (rd_log[0] !== a) begin failures++; $display("FAIL read_addr got=%h exp=%h", rd_log[0], a); end
            end
            checks++; if (cap !== ref_mem[a]) begin failures++; $display("FAIL read_data got=%h exp=%h", cap, ref_mem[a]); end
            checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL read_wr_en got=%0d exp=0", wr_log.size()); end
            $display("read addr=%h data=%h", a, cap);
        end
    endtask

    task automatic test_abort();
        logic m;
        logic [7:0]  cmd;
        logic [31:0] d;
        cmd = {1'b1, 7'($urandom)};
        d = $urandom;
        align();
        wr_log.delete();
        spi_cs = 1'b0;
        #(HALF);
        for (int i = 0; i < 20; i++) send_bit((i < 8) ? cmd[7-i] : d[39-i], m);
        checks++; if (busy !== 1'b1 || spi_miso_oe !== 1'b1) begin failures++; $display("FAIL abort_midframe busy=%b oe=%b exp=1,1", busy, spi_miso_oe); end
        spi_cs = 1'b1;
        #200;
`ifdef SPI_SLAVE_ERR_CNT_EN
        exp_err++;
`endif
        checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL abort_wr_en got=%0d exp=0", wr_log.size()); end
        checks++; if (frame_err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL abort_errcnt got=%0d exp=%0d", frame_err_cnt, exp_err); end
        checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin failures++; $display("FAIL abort_idle busy=%b oe=%b exp=0,0", busy, spi_miso_oe); end
        $display("abort cmd=%h after 20 bits errcnt=%0d", cmd, frame_err_cnt);
    endtask

    task automatic test_long_frame();
        logic [31:0] cap, d;
        logic [6:0]  a;
        a = 7'($urandom);
        d = $urandom;
        align();
        run_frame({1'b1, a}, d, 48, 1'b0, 200, cap);
        ref_mem[a] = d;
        checks++; if (wr_log.size() != 1) begin failures++; $display("FAIL long_count got=%0d exp=1", wr_log.size()); end
        else begin
            checks++; if (wr_log[0] !== {a, d}) begin failures++; $display("FAIL long_data got=%h exp=%h", wr_log[0], {a, d}); end
        end
        checks++; if (frame_err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL long_errcnt got=%0d exp=%0d", frame_err_cnt, exp_err); end
        $display("long write 48 sclk addr=%h data=%h", a, d);
    endtask

    task automatic test_cs_on_last_edge();
        logic [31:0] cap, d;
        logic [6:0]  a;
        a = 7'($urandom);
        d = $urandom;
        align();
        run_frame({1'b1, a}, d, 40, 1'b1, 200, cap);
        ref_mem[a] = d;
        checks++; if (wr_log.size() != 1) begin failures++; $display("FAIL cs_last_count got=%0d exp=1", wr_log.size()); end
        checks++; if (frame_err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL cs_last_errcnt got=%0d exp=%0d", frame_err_cnt, exp_err); end
        $display("write with cs on last edge addr=%h data=%h", a, d);
    endtask

    task automatic test_reset_mid_read();
        logic m;
        logic [31:0] cap;
        logic [7:0]  cmd;
        cmd = 8'h01;
        align();
        spi_cs = 1'b0;
        #(HALF);
        for (int i = 0; i < 12; i++) send_bit((i < 8) ? cmd[7-i] : 1'($urandom), m);
        rst = 1'b1;
        exp_err = 0;
        @(negedge sys_clk);
        checks++; if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_pins miso=%b oe=%b busy=%b exp=0", spi_miso, spi_miso_oe, busy); end
        checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0 || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin failures++; $display("FAIL midrst_regs rd=%b wr=%b ra=%h wa=%h wd=%h exp=0", rd_en, wr_en, rd_addr, wr_addr, wr_data); end
        checks++; if (frame_err_cnt !== 16'd0) begin failures++; $display("FAIL midrst_errcnt got=%0d exp=0", frame_err_cnt); end
        align();
        rst = 1'b0;
        // CS is still low: clocking must not start a frame without a fresh CS fall
        wr_log.delete();
        rd_log.delete();
        for (int i = 0; i < 16; i++) send_bit((i == 0) ? 1'b1 : 1'($urandom), m);
        checks++; if (wr_log.size() != 0 || rd_log.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_no_frame wr=%0d rd=%0d busy=%b exp=0", wr_log.size(), rd_log.size(), busy); end
        spi_cs = 1'b1;
        #200;
        run_frame(cmd, 32'h0, 40, 1'b0, 200, cap);
        checks++; if (rd_log.size() != 1 || cap !== ref_mem[1]) begin failures++; $display("FAIL midrst_read cnt=%0d got=%h exp=%h", rd_log.size(), cap, ref_mem[1]); end
        $display("reset mid-read then read addr=01 data=%h", cap);
    endtask

    task automatic test_back_to_back();
        logic [31:0] cap, d;
        logic [6:0]  a;
        align();
        for (int n = 0; n < 2; n++) begin
            a = 7'($urandom);
            d = $urandom;
            run_frame({1'b1, a}, d, 40, 1'b0, 40, cap);
            ref_mem[a] = d;
            checks++; if (wr_log.size() != 1 || wr_log[0] !== {a, d}) begin failures++; $display("FAIL b2b_write cnt=%0d got=%h exp=%h", wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : '0, {a, d}); end
            run_frame({1'b0, a}, 32'h0, 40, 1'b0, 40, cap);
            checks++; if (rd_log.size() != 1 || cap !== ref_mem[a]) begin failures++; $display("FAIL b2b_read cnt=%0d got=%h exp=%h", rd_log.size(), cap, ref_mem[a]); end
            $display("back-to-back write/read addr=%h data=%h readback=%h", a, d, cap);
        end
        #200;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            reg_file[i] = v;
            ref_mem[i]  = v;
        end
        reg_file[7'h12] = 32'h12345678;
        ref_mem[7'h12]  = 32'h12345678;

        test_reset();
        test_write();
        test_read();
        test_abort();
        test_long_frame();
        test_cs_on_last_edge();
        test_back_to_back();
        test_reset_mid_read();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
